// File: rtl/ssp_reg_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ssp_reg_bridge_if
// Description : Signal bundle between an SSP slave shift engine and the
//               register bridge. The SSP slave (master modport) presents the
//               decoded address, command, field enable, end-of-cycle flag and
//               received data word. It takes back the read-back word.
//               Ports:
//                 ssp_ra  [2:0]  register address (SCK domain)
//                 ssp_wnr        1 = write, 0 = read
//                 ssp_en         field enable, high from bit 4 through bit 15
//                 ssp_eoc        end-of-cycle, high during bit 15 until SSEL
//                                is deasserted
//                 ssp_di  [11:0] received data, valid after the last SCK edge
//                 ssp_do  [11:0] read-back data returned to the SSP slave
// Revision    : 1.0 - initial release
// ============================================================================
interface ssp_reg_bridge_if;
    logic [2:0]  ssp_ra;
    logic        ssp_wnr;
    logic        ssp_en;
    logic        ssp_eoc;
    logic [11:0] ssp_di;
    logic [11:0] ssp_do;

    modport master (
        output ssp_ra,
        output ssp_wnr,
        output ssp_en,
        output ssp_eoc,
        output ssp_di,
        input  ssp_do
    );

    modport slave (
        input  ssp_ra,
        input  ssp_wnr,
        input  ssp_en,
        input  ssp_eoc,
        input  ssp_di,
        output ssp_do
    );
endinterface
`default_nettype wire

// File: rtl/ssp_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ssp_reg_bridge
// Description : Moves completed 16-bit SSP frames from the SCK domain into the
//               clk domain. It commits writes to six 12-bit control registers
//               and returns read-back data to the SSP slave. It pulses a pop
//               strobe after the read-only FIFO port (address 7) has been read
//               and counts frames aborted before bit 15.
//               Ports:
//                 clk, rst       system clock, synchronous active-high reset
//                 ssp            SSP slave bundle (slave modport)
//                 cr     [71:0]  CR0..CR5 packed, CRn at [12n+11:12n]
//                 status [11:0]  live status word, read at address 6
//                 fifo_do[11:0]  FIFO head word, read at address 7
//                 fifo_pop       one-clk pulse after address 7 was read
//                 wr_stb         one-clk pulse per committed write to 0..6
//                 wr_addr [2:0]  address of the last committed write
//                 abort_cnt      saturating count of aborted frames
// Revision    : 1.0 - initial release
// ============================================================================
module ssp_reg_bridge #(
    parameter logic [71:0] CR_RST  = 72'h0,
    parameter int          ABORT_W = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    ssp_reg_bridge_if.slave         ssp,
    output logic [71:0]             cr,
    input  wire logic [11:0]        status,
    input  wire logic [11:0]        fifo_do,
    output logic                    fifo_pop,
    output logic                    wr_stb,
    output logic [2:0]              wr_addr,
    output logic [ABORT_W-1:0]      abort_cnt
);

    localparam int         c_num_cr    = 6;
    localparam logic [2:0] c_addr_stat = 3'd6;
    localparam logic [2:0] c_addr_fifo = 3'd7;

    // Synchronizers (2 flops) plus one history flop each for edge detection
    logic r_eoc_s1, r_eoc_s2, r_eoc_h;
    logic r_en_s1,  r_en_s2,  r_en_h;

    // Frame registers captured on commit, and the one-clk action stage flag
    logic [2:0]  r_f_ra;
    logic        r_f_wnr;
    logic [11:0] r_f_di;
    logic        r_act;

    logic [71:0]        r_cr;
    logic [11:0]        r_stat_shadow;
    logic [ABORT_W-1:0] r_abort_cnt;
    logic               r_wr_stb;
    logic [2:0]         r_wr_addr;
    logic               r_fifo_pop;

    logic        w_commit;
    logic        w_abort;
    logic        w_idle;
    logic        w_wr_cr;
    logic        w_wr_stat;
    logic        w_pop;
    logic [11:0] w_do;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eoc_s1 <= 1'b0;
            r_eoc_s2 <= 1'b0;
            r_eoc_h  <= 1'b0;
            r_en_s1  <= 1'b0;
            r_en_s2  <= 1'b0;
            r_en_h   <= 1'b0;
        end else begin
            r_eoc_s1 <= ssp.ssp_eoc;
            r_eoc_s2 <= r_eoc_s1;
            r_eoc_h  <= r_eoc_s2;
            r_en_s1  <= ssp.ssp_en;
            r_en_s2  <= r_en_s1;
            r_en_h   <= r_en_s2;
        end
    end

    // A full frame ends with a falling edge of EOC. An En falling edge
    // without EOC having been seen means SSEL went away before bit 15.
    assign w_commit = r_eoc_h & ~r_eoc_s2;
    assign w_abort  = r_en_h & ~r_en_s2 & ~r_eoc_h;
    assign w_idle   = ~r_en_s2 & ~r_eoc_s2;

    assign w_wr_cr   = r_act &  r_f_wnr & (r_f_ra < 3'(c_num_cr));
    assign w_wr_stat = r_act &  r_f_wnr & (r_f_ra == c_addr_stat);
    assign w_pop     = r_act & ~r_f_wnr & (r_f_ra == c_addr_fifo);

    // RA/WnR/DI are quasi-static once SSEL is high, so they are sampled
    // directly on commit without synchronization.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_ra  <= 3'd0;
            r_f_wnr <= 1'b0;
            r_f_di  <= 12'd0;
            r_act   <= 1'b0;
        end else begin
            r_act <= w_commit;
            if (w_commit) begin
                r_f_ra  <= ssp.ssp_ra;
                r_f_wnr <= ssp.ssp_wnr;
                r_f_di  <= ssp.ssp_di;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cr <= CR_RST;
        end else if (w_wr_cr) begin
            for (int i = 0; i < c_num_cr; i++) begin
                if (r_f_ra == 3'(i)) begin
                    r_cr[12*i +: 12] <= r_f_di;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_stb   <= 1'b0;
            r_wr_addr  <= 3'd0;
            r_fifo_pop <= 1'b0;
        end else begin
            r_wr_stb   <= w_wr_cr | w_wr_stat;
            r_fifo_pop <= w_pop;
            if (w_wr_cr | w_wr_stat) begin
                r_wr_addr <= r_f_ra;
            end
        end
    end

    // A write to address 6 clears the counter and takes priority over an
    // abort seen in the same clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_abort_cnt <= '0;
        end else if (w_wr_stat) begin
            r_abort_cnt <= '0;
        end else if (w_abort && (r_abort_cnt != {ABORT_W{1'b1}})) begin
            r_abort_cnt <= r_abort_cnt + ABORT_W'(1);
        end
    end

    // Status is frozen while a frame is in flight so the word being shifted
    // out cannot change under the SCK sampling window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_shadow <= 12'd0;
        end else if (w_idle) begin
            r_stat_shadow <= status;
        end
    end

    always_comb begin
        w_do = 12'd0;
        case (ssp.ssp_ra)
            3'd0:        w_do = r_cr[11:0];
            3'd1:        w_do = r_cr[23:12];
            3'd2:        w_do = r_cr[35:24];
            3'd3:        w_do = r_cr[47:36];
            3'd4:        w_do = r_cr[59:48];
            3'd5:        w_do = r_cr[71:60];
            c_addr_stat: w_do = r_stat_shadow;
            c_addr_fifo: w_do = fifo_do;
        endcase
    end

    assign ssp.ssp_do = w_do;
    assign cr         = r_cr;
    assign wr_stb     = r_wr_stb;
    assign wr_addr    = r_wr_addr;
    assign fifo_pop   = r_fifo_pop;
    assign abort_cnt  = r_abort_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ssp_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssp_reg_bridge
// Description : Self-checking bench for ssp_reg_bridge. It drives SSP frames
//               at the field level (En/EOC timing in clk units, 2 clk per SCK
//               bit) and checks against a register-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssp_reg_bridge;

    localparam logic [71:0] C_CR_RST  = 72'h5A3_0F0_C3C_111_ABC_7E1;
    localparam int          C_ABORT_W = 4;
    localparam int          C_SAT     = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] cr;
    logic [11:0] status;
    logic [11:0] fifo_do;
    logic        fifo_pop;
    logic        wr_stb;
    logic [2:0]  wr_addr;
    logic [C_ABORT_W-1:0] abort_cnt;

    always #5 clk = ~clk;

    ssp_reg_bridge_if bus ();

    ssp_reg_bridge #(
        .CR_RST  (C_CR_RST),
        .ABORT_W (C_ABORT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ssp       (bus),
        .cr        (cr),
        .status    (status),
        .fifo_do   (fifo_do),
        .fifo_pop  (fifo_pop),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .abort_cnt (abort_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Pulse counters observed away from the active edge
    int stb_cnt = 0;
    int pop_cnt = 0;
    always @(negedge clk) begin
        if (wr_stb === 1'b1)   stb_cnt++;
        if (fifo_pop === 1'b1) pop_cnt++;
    end

    // Reference model
    logic [11:0] m_cr [6];
    int          m_abort;
    logic [2:0]  m_wr_addr;
    logic [11:0] m_shadow;
    logic [11:0] do_mid;

    task automatic model_reset();
        logic [71:0] v;
        v = C_CR_RST;
        for (int i = 0; i < 6; i++) m_cr[i] = v[12*i +: 12];
        m_abort   = 0;
        m_wr_addr = 3'd0;
    endtask

    function automatic logic [71:0] model_cr();
        logic [71:0] v;
        for (int i = 0; i < 6; i++) v[12*i +: 12] = m_cr[i];
        return v;
    endfunction

    // Register-level effect of one frame of nbits bits.
    task automatic model_frame(input logic [2:0] ra, input logic wnr,
                               input logic [11:0] di, input int nbits,
                               output int exp_stb, output int exp_pop);
        exp_stb = 0;
        exp_pop = 0;
        if (nbits == 16) begin
            if (wnr && ra <= 3'd6) begin
                exp_stb   = 1;
                m_wr_addr = ra;
                if (ra == 3'd6) m_abort = 0;
                else            m_cr[ra] = di;
            end
            if (!wnr && ra == 3'd7) exp_pop = 1;
        end else if (nbits > 4) begin
            if (m_abort < C_SAT) m_abort++;
        end
    endtask

    function automatic logic [11:0] model_read(input logic [2:0] ra);
        if (ra == 3'd6) return m_shadow;
        if (ra == 3'd7) return fifo_do;
        return m_cr[ra];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bits b_from..b_to of a frame, 2 clk per bit. En rises at bit 4,
    // EOC at bit 15. The read-back word is sampled during bit 8.
    task automatic drive_bits(input int b_from, input int b_to,
                              input logic [2:0] ra, input logic wnr,
                              input logic [11:0] di);
        for (int b = b_from; b <= b_to; b++) begin
            if (b == 0) begin
                status   = 12'($urandom);
                m_shadow = status;
            end
            if (b == 4) begin
                bus.ssp_ra  = ra;
                bus.ssp_wnr = wnr;
                bus.ssp_en  = 1'b1;
            end
            if (b == 6)  status = 12'($urandom);
            if (b == 15) bus.ssp_eoc = 1'b1;
            bus.ssp_di = 12'($urandom);
            tick(1);
            if (b == 15) bus.ssp_di = di;
            tick(1);
            if (b == 8) do_mid = bus.ssp_do;
        end
    endtask

    // SSEL deassertion: EOC drops now, En drops en_lag clocks later.
    task automatic end_frame(input int en_lag);
        bus.ssp_eoc = 1'b0;
        if (en_lag > 0) tick(en_lag);
        bus.ssp_en = 1'b0;
        tick(8);
    endtask

    task automatic run_frame(input logic [2:0] ra, input logic wnr,
                             input logic [11:0] di, input int nbits);
        drive_bits(0, nbits - 1, ra, wnr, di);
        end_frame(0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ssp_ra = 3'd6; bus.ssp_wnr = 1'b0; bus.ssp_en = 1'b0;
        bus.ssp_eoc = 1'b0; bus.ssp_di = 12'd0;
        status = 12'h9C3; fifo_do = 12'h000;
        model_reset();
        tick(4);
        checks++; if (cr !== model_cr()) begin errors++; $display("FAIL reset_cr: got %h expected %h", cr, model_cr()); end
        checks++; if (abort_cnt !== 4'd0) begin errors++; $display("FAIL reset_abort: got %h expected 0", abort_cnt); end
        checks++; if ({wr_stb, fifo_pop, wr_addr} !== 5'd0) begin errors++; $display("FAIL reset_strobes: got stb=%b pop=%b addr=%h expected 0", wr_stb, fifo_pop, wr_addr); end
        checks++; if (bus.ssp_do !== 12'd0) begin errors++; $display("FAIL reset_shadow: got %h expected 000", bus.ssp_do); end
        rst = 1'b0;
        tick(4);
        checks++; if (bus.ssp_do !== 12'h9C3) begin errors++; $display("FAIL idle_shadow: got %h expected 9c3", bus.ssp_do); end
        bus.ssp_ra = 3'd2;
        #1;
        checks++; if (bus.ssp_do !== m_cr[2]) begin errors++; $display("FAIL reset_read_cr2: got %h expected %h", bus.ssp_do, m_cr[2]); end
    endtask

    task automatic test_write();
        int s0, es, ep;
        s0 = stb_cnt;
        drive_bits(0, 15, 3'd2, 1'b1, 12'hA5C);
        bus.ssp_eoc = 1'b0;
        bus.ssp_en  = 1'b0;
        tick(5);
        checks++; if (cr[35:24] !== 12'hA5C) begin errors++; $display("FAIL write_latency: got cr2=%h expected a5c", cr[35:24]); end
        tick(3);
        model_frame(3'd2, 1'b1, 12'hA5C, 16, es, ep);
        checks++; if (cr !== model_cr()) begin errors++; $display("FAIL write_cr: got %h expected %h", cr, model_cr()); end
        checks++; if (stb_cnt - s0 !== es) begin errors++; $display("FAIL write_stb: got %0d expected %0d", stb_cnt - s0, es); end
        checks++; if (wr_addr !== 3'd2) begin errors++; $display("FAIL write_addr: got %h expected 2", wr_addr); end
    endtask

    task automatic test_read();
        int s0, p0, es, ep;
        s0 = stb_cnt; p0 = pop_cnt;
        run_frame(3'd2, 1'b0, 12'($urandom), 16);
        model_frame(3'd2, 1'b0, 12'd0, 16, es, ep);
        checks++; if (do_mid !== 12'hA5C) begin errors++; $display("FAIL read_do: got %h expected a5c", do_mid); end
        checks++; if (stb_cnt - s0 !== 0 || pop_cnt - p0 !== 0) begin errors++; $display("FAIL read_side_effect: got stb=%0d pop=%0d expected 0 0", stb_cnt - s0, pop_cnt - p0); end
        checks++; if (cr !== model_cr()) begin errors++; $display("FAIL read_cr: got %h expected %h", cr, model_cr()); end
    endtask

    task automatic test_fifo_read();
        logic [11:0] words [2];
        int p0, es, ep;
        words[0] = 12'h123; words[1] = 12'h456;
        for (int i = 0; i < 2; i++) begin
            fifo_do = words[i];
            p0 = pop_cnt;
            run_frame(3'd7, 1'b0, 12'($urandom), 16);
            model_frame(3'd7, 1'b0, 12'd0, 16, es, ep);
            checks++; if (do_mid !== words[i]) begin errors++; $display("FAIL fifo_do_%0d: got %h expected %h", i, do_mid, words[i]); end
            checks++; if (pop_cnt - p0 !== ep) begin errors++; $display("FAIL fifo_pop_%0d: got %0d expected %0d", i, pop_cnt - p0, ep); end
        end
    endtask

    task automatic test_abort_saturate();
        int s0, p0, es, ep;
        logic [2:0] ra;
        logic wnr;
        s0 = stb_cnt; p0 = pop_cnt;
        for (int i = 0; i < 17; i++) begin
            ra = 3'($urandom_range(0, 7));
            wnr = 1'($urandom);
            run_frame(ra, wnr, 12'($urandom), 9);
            model_frame(ra, wnr, 12'd0, 9, es, ep);
            checks++; if (int'(abort_cnt) !== m_abort) begin errors++; $display("FAIL abort_cnt_%0d: got %0d expected %0d", i, abort_cnt, m_abort); end
        end
        checks++; if (cr !== model_cr()) begin errors++; $display("FAIL abort_cr: got %h expected %h", cr, model_cr()); end
        checks++; if (stb_cnt - s0 !== 0 || pop_cnt - p0 !== 0) begin errors++; $display("FAIL abort_side_effect: got stb=%0d pop=%0d expected 0 0", stb_cnt - s0, pop_cnt - p0); end
    endtask

    // En falls one clk after EOC, so its abort edge lands in the same clk
    // as the write-6 action; the clear must win.
    task automatic test_clear_coincident();
        int s0, es, ep;
        s0 = stb_cnt;
        drive_bits(0, 15, 3'd6, 1'b1, 12'd0);
        end_frame(1);
        checks++; if (do_mid !== m_shadow) begin errors++; $display("FAIL shadow_frozen: got %h expected %h", do_mid, m_shadow); end
        model_frame(3'd6, 1'b1, 12'd0, 16, es, ep);
        checks++; if (int'(abort_cnt) !== m_abort) begin errors++; $display("FAIL clear_wins: got %0d expected %0d", abort_cnt, m_abort); end
        checks++; if (stb_cnt - s0 !== es || wr_addr !== 3'd6) begin errors++; $display("FAIL clear_stb: got stb=%0d addr=%h expected %0d 6", stb_cnt - s0, wr_addr, es); end
        checks++; if (cr !== model_cr()) begin errors++; $display("FAIL clear_cr: got %h expected %h", cr, model_cr()); end
        status = 12'($urandom);
        tick(4);
        checks++; if (bus.ssp_do !== status) begin errors++; $display("FAIL status_readback: got %h expected %h", bus.ssp_do, status); end
    endtask

    task automatic test_reset_mid_frame();
        int s0, p0, es, ep;
        drive_bits(0, 7, 3'd5, 1'b1, 12'($urandom));
        rst = 1'b1;
        bus.ssp_en = 1'b0; bus.ssp_eoc = 1'b0;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(4);
        s0 = stb_cnt; p0 = pop_cnt;
        run_frame(3'd0, 1'b1, 12'h7FF, 16);
        model_frame(3'd0, 1'b1, 12'h7FF, 16, es, ep);
        checks++; if (cr !== model_cr()) begin errors++; $display("FAIL rstmid_cr: got %h expected %h", cr, model_cr()); end
        checks++; if (abort_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_abort: got %0d expected 0", abort_cnt); end
        checks++; if (stb_cnt - s0 !== es || pop_cnt - p0 !== ep || wr_addr !== 3'd0) begin errors++; $display("FAIL rstmid_strobes: got stb=%0d pop=%0d addr=%h expected %0d %0d 0", stb_cnt - s0, pop_cnt - p0, wr_addr, es, ep); end
        checks++; if (wr_stb !== 1'b0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got stb=%b pop=%b expected 0 0", wr_stb, fifo_pop); end
    endtask

    task automatic test_reset_release();
        int s0, es, ep;
        logic [11:0] d;
        // En still high at release: its later fall is an abort
        drive_bits(0, 9, 3'd3, 1'b1, 12'($urandom));
        rst = 1'b1; tick(3); rst = 1'b0;
        model_reset();
        tick(4);
        bus.ssp_en = 1'b0;
        tick(8);
        m_abort = 1;
        checks++; if (int'(abort_cnt) !== m_abort) begin errors++; $display("FAIL release_abort: got %0d expected %0d", abort_cnt, m_abort); end
        // EOC already high at release: the frame commits
        d = 12'($urandom);
        s0 = stb_cnt;
        drive_bits(0, 15, 3'd4, 1'b1, d);
        rst = 1'b1; tick(3); rst = 1'b0;
        model_reset();
        tick(4);
        end_frame(0);
        model_frame(3'd4, 1'b1, d, 16, es, ep);
        checks++; if (cr !== model_cr() || wr_addr !== 3'd4) begin errors++; $display("FAIL release_commit: got cr=%h addr=%h expected %h 4", cr, wr_addr, model_cr()); end
        checks++; if (stb_cnt - s0 !== es || abort_cnt !== 4'd0) begin errors++; $display("FAIL release_stb: got stb=%0d abort=%0d expected %0d 0", stb_cnt - s0, abort_cnt, es); end
    endtask

    task automatic test_random();
        int s0, p0, es, ep, nbits, kind;
        logic [2:0]  ra;
        logic        wnr;
        logic [11:0] di, exp_do;
        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 9));
            nbits = (kind == 0) ? int'($urandom_range(1, 3)) :
                    (kind <= 2) ? int'($urandom_range(5, 15)) : 16;
            ra  = 3'($urandom_range(0, 7));
            wnr = 1'($urandom);
            di  = 12'($urandom);
            fifo_do = 12'($urandom);
            s0 = stb_cnt; p0 = pop_cnt;
            run_frame(ra, wnr, di, nbits);
            exp_do = model_read(ra);
            model_frame(ra, wnr, di, nbits, es, ep);
            if (nbits > 8) begin
                checks++; if (do_mid !== exp_do) begin errors++; $display("FAIL rnd_do_%0d: got %h expected %h ra=%0d", i, do_mid, exp_do, ra); end
            end
            checks++; if (stb_cnt - s0 !== es || pop_cnt - p0 !== ep) begin errors++; $display("FAIL rnd_pulses_%0d: got stb=%0d pop=%0d expected %0d %0d", i, stb_cnt - s0, pop_cnt - p0, es, ep); end
            checks++; if (cr !== model_cr()) begin errors++; $display("FAIL rnd_cr_%0d: got %h expected %h", i, cr, model_cr()); end
            checks++; if (int'(abort_cnt) !== m_abort || wr_addr !== m_wr_addr) begin errors++; $display("FAIL rnd_state_%0d: got abort=%0d addr=%h expected %0d %h", i, abort_cnt, wr_addr, m_abort, m_wr_addr); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fifo_read();
        test_abort_saturate();
        test_clear_coincident();
        test_reset_mid_frame();
        test_reset_release();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
